// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        mm_req;
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_valid;
  logic        mm_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        err;

  modport slave (
    input  if_req, if_addr, mm_req, mm_we, mm_addr, mm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall, mm_rdata, mm_valid, mm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, mm_req, mm_we, mm_addr, mm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall, mm_rdata, mm_valid, mm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between a fetch requester and a data requester, with
// data priority bounded by MAX_MM_BURST and a per-access ack timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT      = 15,
  parameter int MAX_MM_BURST = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_MM_BURST + 2);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MM_BURST);
  localparam logic [3:0]    WCNT_LAST  = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q,     state_d;
  logic            own_mm_q,    own_mm_d;
  logic [31:0]     addr_q,      addr_d;
  logic            we_q,        we_d;
  logic [31:0]     wdata_q,     wdata_d;
  logic [31:0]     if_rdata_q,  if_rdata_d;
  logic [31:0]     mm_rdata_q,  mm_rdata_d;
  logic [3:0]      wcnt_q,      wcnt_d;
  logic [SW-1:0]   streak_q,    streak_d;
  logic            tmo_q,       tmo_d;
  logic            mm_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      own_mm_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      mm_rdata_q <= '0;
      wcnt_q     <= '0;
      streak_q   <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_mm_q   <= own_mm_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      mm_rdata_q <= mm_rdata_d;
      wcnt_q     <= wcnt_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    // Data keeps the port unless it has already won MAX_MM_BURST times in a row over a waiting fetch.
    mm_wins    = bus.mm_req && !(bus.if_req && (streak_q == STREAK_MAX));
    state_d    = state_q;
    own_mm_d   = own_mm_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    mm_rdata_d = mm_rdata_q;
    wcnt_d     = wcnt_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (mm_wins) begin
          own_mm_d = 1'b1;
          addr_d   = bus.mm_addr;
          we_d     = bus.mm_we;
          wdata_d  = bus.mm_wdata;
          if (bus.if_req) streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          else            streak_d = '0;
          wcnt_d   = '0;
          tmo_d    = 1'b0;
          state_d  = BUSY;
        end else if (bus.if_req) begin
          own_mm_d = 1'b0;
          addr_d   = bus.if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
          wcnt_d   = '0;
          tmo_d    = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // An ack on the last allowed cycle still completes normally.
        if (bus.mem_ack) begin
          if (own_mm_q) mm_rdata_d = bus.mem_rdata;
          else          if_rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else if (wcnt_q == WCNT_LAST) begin
          if (own_mm_q) mm_rdata_d = '0;
          else          if_rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req   = (state_q == BUSY);
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.if_rdata  = if_rdata_q;
    bus.mm_rdata  = mm_rdata_q;
    bus.if_valid  = (state_q == DONE) && !own_mm_q;
    bus.mm_valid  = (state_q == DONE) && own_mm_q;
    bus.err       = (state_q == DONE) && tmo_q;
    bus.if_stall  = bus.if_req & ~((state_q == DONE) && !own_mm_q);
    bus.mm_stall  = bus.mm_req & ~((state_q == DONE) && own_mm_q);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts each
// grant, its busy length and its outcome; a negedge monitor scores the DUT against it.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 15;
  localparam int MAXB    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .MAX_MM_BURST(MAXB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          mm;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          tmo;
    int          blen;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] data;
  } plan_t;

  exp_t  expq[$];
  plan_t planq[$];

  int errors = 0;
  int checks = 0;

  // Requester/model state, index 0 = fetch, 1 = data
  bit          pend[2];
  bit          grn[2];
  bit          drp[2];
  int          done_c[2];
  logic [31:0] raddr[2];
  logic [31:0] rwd[2];
  bit          rwe[2];
  logic [31:0] last_rd[2];
  int          cyc;
  int          idle_c;
  int          streak;
  int          req_pct;
  bit          gen_en;
  bit          mon_en;
  bit          mem_prev;
  int          bidx;
  plan_t       cur_plan;

  // Monitor state
  bit   mon_prev;
  bit   have;
  int   blen;
  exp_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_cycle();
    int    o;
    int    k;
    int    d;
    int    b;
    bit    tmo;
    exp_t  e;
    plan_t p;
    for (int r = 0; r < 2; r++) begin
      if (pend[r] && grn[r] && done_c[r] == cyc - 1) begin
        pend[r] = 1'b0;
        grn[r]  = 1'b0;
        drp[r]  = 1'b0;
      end
      if (!pend[r]) begin
        raddr[r] = $urandom;
        rwd[r]   = $urandom;
        rwe[r]   = (r == 1) ? 1'($urandom_range(1)) : 1'b0;
        if (gen_en && int'($urandom_range(99)) < req_pct) pend[r] = 1'b1;
      end
    end
    bus.if_req   = pend[0] && !drp[0];
    bus.if_addr  = raddr[0];
    bus.mm_req   = pend[1] && !drp[1];
    bus.mm_addr  = raddr[1];
    bus.mm_we    = rwe[1];
    bus.mm_wdata = rwd[1];

    if (cyc == idle_c) begin
      if (pend[0] || pend[1]) begin
        o = (pend[1] && !(pend[0] && streak == MAXB)) ? 1 : 0;
        if (o == 1) streak = pend[0] ? ((streak < MAXB) ? streak + 1 : MAXB) : 0;
        else        streak = 0;
        k = int'($urandom_range(99));
        if      (k < 40) d = 0;
        else if (k < 75) d = int'($urandom_range(5, 1));
        else if (k < 88) d = TIMEOUT - 1;
        else             d = int'($urandom_range(TIMEOUT + 4, TIMEOUT));
        tmo     = (d > TIMEOUT - 1);
        b       = tmo ? TIMEOUT : d + 1;
        p.d     = d;
        p.data  = $urandom;
        e.mm    = (o == 1);
        e.addr  = raddr[o];
        e.we    = (o == 1) ? rwe[1] : 1'b0;
        e.wdata = rwd[1];
        e.rdata = tmo ? 32'h0 : p.data;
        e.tmo   = tmo;
        e.blen  = b;
        expq.push_back(e);
        planq.push_back(p);
        done_c[o] = cyc + b + 1;
        idle_c    = cyc + b + 2;
        grn[o]    = 1'b1;
        drp[o]    = ($urandom_range(3) == 0);
      end else begin
        idle_c = cyc + 1;
      end
    end

    // Memory model: ack per plan while busy, random (ignored) acks otherwise
    if (bus.mem_req) begin
      if (!mem_prev) begin
        if (planq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL plan_avail at cycle %0d: got mem_req with no predicted grant", cyc);
        end else begin
          cur_plan = planq.pop_front();
        end
        bidx = 0;
      end
      bidx++;
      bus.mem_ack   = (bidx == cur_plan.d + 1);
      bus.mem_rdata = bus.mem_ack ? cur_plan.data : $urandom;
    end else begin
      bus.mem_ack   = ($urandom_range(3) == 0);
      bus.mem_rdata = $urandom;
    end
    mem_prev = bus.mem_req;
  endtask

  initial begin : monitor
    bit ev0;
    bit ev1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ev0 = (cyc == done_c[0]);
        ev1 = (cyc == done_c[1]);
        chk("if_valid", 32'(bus.if_valid), 32'(ev0));
        chk("mm_valid", 32'(bus.mm_valid), 32'(ev1));
        chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req & ~ev0));
        chk("mm_stall", 32'(bus.mm_stall), 32'(bus.mm_req & ~ev1));
        if (bus.mem_req) begin
          if (!mon_prev) begin
            if (expq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL grant at cycle %0d: got unexpected mem_req", cyc);
              have = 1'b0;
            end else begin
              cur  = expq.pop_front();
              have = 1'b1;
            end
            blen = 0;
          end
          blen++;
          if (have) begin
            chk("mem_addr", bus.mem_addr, cur.addr);
            chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
            if (cur.mm) chk("mem_wdata", bus.mem_wdata, cur.wdata);
          end
        end
        mon_prev = bus.mem_req;
        if (bus.if_valid || bus.mm_valid) begin
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL completion at cycle %0d: got valid with no transaction", cyc);
          end else begin
            chk("owner", 32'(bus.mm_valid), 32'(cur.mm));
            chk("busy_len", 32'(blen), 32'(cur.blen));
            chk("rdata", cur.mm ? bus.mm_rdata : bus.if_rdata, cur.rdata);
            chk("err", 32'(bus.err), 32'(cur.tmo));
            last_rd[cur.mm ? 1 : 0] = cur.rdata;
            have = 1'b0;
          end
        end else begin
          chk("err_idle", 32'(bus.err), 32'h0);
        end
        chk("if_rdata_hold", bus.if_rdata, last_rd[0]);
        chk("mm_rdata_hold", bus.mm_rdata, last_rd[1]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    mon_en = 1'b0;
    gen_en = 1'b0;
    cyc = 0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mm_req = 1'b0; bus.mm_we = 1'b0; bus.mm_addr = '0; bus.mm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",   32'(bus.mem_req), 32'h0);
    chk("rst_mem_we",    32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr",  bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_if_rdata",  bus.if_rdata, 32'h0);
    chk("rst_mm_rdata",  bus.mm_rdata, 32'h0);
    chk("rst_if_valid",  32'(bus.if_valid), 32'h0);
    chk("rst_mm_valid",  32'(bus.mm_valid), 32'h0);
    chk("rst_err",       32'(bus.err), 32'h0);

    // Fetch aborted by reset on its 2nd busy cycle, then served afresh
    @(posedge clk); #1;
    rst = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk("d_idle_stall", 32'(bus.if_stall), 32'h1);
    chk("d_idle_memreq", 32'(bus.mem_req), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("d_busy1_memreq", 32'(bus.mem_req), 32'h1);
    chk("d_busy1_addr", bus.mem_addr, 32'h40);
    chk("d_busy1_we", 32'(bus.mem_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("d_busy2_memreq", 32'(bus.mem_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("d_rst_memreq", 32'(bus.mem_req), 32'h0);
    chk("d_rst_valid", 32'(bus.if_valid), 32'h0);
    chk("d_rst_err", 32'(bus.err), 32'h0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("d_serve_memreq", 32'(bus.mem_req), 32'h1);
    chk("d_serve_addr", bus.mem_addr, 32'h40);
    chk("d_serve_novalid", 32'(bus.if_valid), 32'h0);
    chk("d_serve_stall", 32'(bus.if_stall), 32'h1);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    chk("d_done_valid", 32'(bus.if_valid), 32'h1);
    chk("d_done_rdata", bus.if_rdata, 32'h12345678);
    chk("d_done_err", 32'(bus.err), 32'h0);
    chk("d_done_stall", 32'(bus.if_stall), 32'h0);
    chk("d_done_memreq", 32'(bus.mem_req), 32'h0);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("d_after_valid", 32'(bus.if_valid), 32'h0);
    chk("d_after_hold", bus.if_rdata, 32'h12345678);

    // Randomized phase from a fresh reset
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; grn[r] = 1'b0; drp[r] = 1'b0;
      done_c[r] = -100; last_rd[r] = '0;
    end
    cyc = -1; idle_c = 0; streak = 0;
    mem_prev = 1'b0; mon_prev = 1'b0; have = 1'b0;
    gen_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      req_pct = (i < 1500) ? 100 : 40;
      cyc++;
      drive_cycle();
    end
    gen_en = 1'b0;
    for (int i = 0; i < 200 && (pend[0] || pend[1]); i++) begin
      @(posedge clk); #1;
      cyc++;
      drive_cycle();
    end
    repeat (3) begin
      @(posedge clk); #1;
      cyc++;
      drive_cycle();
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("drain_pending", 32'(pend[0] || pend[1]), 32'h0);
    chk("drain_expq", 32'(expq.size()), 32'h0);
    chk("drain_open", 32'(have), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
